// File: rtl/multi_sync_filter.sv
// multi_sync_filter: per-channel async input synchronizer with stability filter and registered edge pulses
module multi_sync_filter #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGE = 3,
    parameter int FILTER_CNT = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             change
);
    localparam int FMAX = (FILTER_CNT < 1) ? 1 : FILTER_CNT;
    localparam int CW = (FILTER_CNT > 0) ? $clog2(FILTER_CNT + 1) : 1;
    localparam logic [CW-1:0] CLAST = CW'(FMAX - 1);
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;
    if (SYNC_STAGE < 2) begin : g_bad_sync
        $error("multi_sync_filter: SYNC_STAGE must be >= 2");
    end
    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_dout;
        assign w_s[c]   = r_sync[SYNC_STAGE-1];
        assign w_upd[c] = (w_s[c] != r_dout) && (r_cnt == CLAST);
        assign dout[c]  = r_dout;
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                r_sync <= {SYNC_STAGE{RESET_VAL[c]}};
                r_cnt  <= '0;
                r_dout <= RESET_VAL[c];
            end else begin
                r_sync <= {r_sync[SYNC_STAGE-2:0], din[c]};
                r_cnt  <= (w_s[c] == r_dout || w_upd[c]) ? '0 : r_cnt + 1'b1;
                r_dout <= w_upd[c] ? w_s[c] : r_dout;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_rise   <= w_upd & w_s;
            r_fall   <= w_upd & ~w_s;
            r_change <= |w_upd;
        end
    end
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign change = r_change;
endmodule

// File: tb/tb_multi_sync_filter.sv
// tb_multi_sync_filter: scoreboard bench for multi_sync_filter (defaults plus a WIDTH=1 latency sweep)
module tb_multi_sync_filter;
    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout, rise, fall;
    logic       change;
    logic       l_rst = 1'b1;
    logic       l_din = 1'b0;
    logic [8:0] l_dout, l_rise, l_fall, l_chg;
    int n_checks = 0;
    int n_err = 0;
    logic [24:0] q_exp[$];
    logic [7:0] m_sh[3];
    logic [7:0] m_dout;
    int m_run[8];

    always #5 clk = ~clk;

    multi_sync_filter u_dut (
        .clk(clk), .sync_reset(sync_reset), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .change(change)
    );

    function automatic int lat_s(input int j);
        return (j < 3) ? 2 : (j < 6) ? 3 : 5;
    endfunction

    function automatic int lat_f(input int j);
        return (j % 3 == 0) ? 0 : (j % 3 == 1) ? 1 : 4;
    endfunction

    for (genvar j = 0; j < 9; j++) begin : g_lat
        multi_sync_filter #(.WIDTH(1), .SYNC_STAGE(lat_s(j)), .FILTER_CNT(lat_f(j))) u_lat (
            .clk(clk), .sync_reset(l_rst), .din(l_din),
            .dout(l_dout[j]), .rise(l_rise[j]), .fall(l_fall[j]), .change(l_chg[j])
        );
    end

    // Reference: s is din delayed 3 edges; an output flips after 4 consecutive differing samples.
    task automatic model_tick(input logic [7:0] d, input logic r);
        logic [7:0] s, upd;
        s = m_sh[2];
        upd = 8'h00;
        if (r) begin
            for (int k = 0; k < 3; k++) m_sh[k] = 8'h00;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            m_dout = 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_run[i] = (s[i] != m_dout[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] >= 4) begin
                    upd[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
            m_dout = m_dout ^ upd;
            m_sh[2] = m_sh[1];
            m_sh[1] = m_sh[0];
            m_sh[0] = d;
        end
        q_exp.push_back({m_dout, upd & m_dout, upd & ~m_dout, |upd});
    endtask

    task automatic tick(input logic [7:0] d, input logic r);
        din = d;
        sync_reset = r;
        model_tick(d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] e;
        for (int k = 0; k < 2; k++) begin
            tick(8'hFF, 1'b1);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== 25'h0) begin
                n_err++;
                $display("FAIL reset_hold got=%h exp=0", {dout, rise, fall, change});
            end
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL reset_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            tick(8'hFF, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== {(k >= 7) ? 8'hFF : 8'h00, (k == 7) ? 8'hFF : 8'h00, 8'h00, k == 7}) begin
                n_err++;
                $display("FAIL reset_release edge=%0d got=%h", k, {dout, rise, fall, change});
            end
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL reset_release_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
        end
    endtask

    task automatic test_latency();
        logic [24:0] e;
        int l;
        for (int k = 0; k < 4; k++) begin
            l_rst = (k < 2);
            tick(8'hFF, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL latency_main_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
        end
        l_din = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(8'hFF, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL latency_main_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
            for (int j = 0; j < 9; j++) begin
                l = lat_s(j) + ((lat_f(j) < 1) ? 1 : lat_f(j));
                n_checks++;
                if ({l_dout[j], l_rise[j], l_fall[j], l_chg[j]} !== {k >= l, k == l, 1'b0, k == l}) begin
                    n_err++;
                    $display("FAIL latency s=%0d f=%0d edge=%0d got=%b exp=%b", lat_s(j), lat_f(j), k,
                             {l_dout[j], l_rise[j], l_fall[j], l_chg[j]}, {k >= l, k == l, 1'b0, k == l});
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [24:0] e;
        int rc, fc, first;
        for (int k = 0; k < 28; k++) begin
            tick((k >= 12 && k < 15) ? 8'h01 : 8'h00, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL glitch_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
            if (k >= 12) begin
                n_checks++;
                if ({dout[0], rise[0], change} !== 3'b000) begin
                    n_err++;
                    $display("FAIL glitch_reject cyc=%0d got=%b exp=000", k, {dout[0], rise[0], change});
                end
            end
        end
        rc = 0;
        fc = 0;
        first = -1;
        for (int k = 0; k < 16; k++) begin
            tick((k < 4) ? 8'h01 : 8'h00, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL glitch_pass_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
            rc += int'(rise[0]);
            fc += int'(fall[0]);
            if (dout[0] && first < 0) first = k + 1;
        end
        n_checks++;
        if (first != 7 || rc != 1 || fc != 1) begin
            n_err++;
            $display("FAIL glitch_pass first=%0d rises=%0d falls=%0d exp 7/1/1", first, rc, fc);
        end
    endtask

    task automatic test_multi();
        logic [24:0] e;
        for (int k = 0; k < 20; k++) begin
            tick((k < 10) ? 8'hA5 : 8'h00, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL multi_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
            n_checks++;
            if ({rise, fall, change} !== ((k == 6) ? {8'hA5, 8'h00, 1'b1} : (k == 16) ? {8'h00, 8'hA5, 1'b1} : 17'h0)) begin
                n_err++;
                $display("FAIL multi_edges cyc=%0d rise=%h fall=%h change=%b", k, rise, fall, change);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] e;
        for (int k = 0; k < 15; k++) begin
            tick(8'h08, k == 5);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL reset_mid_sb got=%h exp=%h", {dout, rise, fall, change}, e);
            end
            n_checks++;
            if ({dout[3], rise[3], change} !== {k >= 12, k == 12, k == 12}) begin
                n_err++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", k, {dout[3], rise[3], change}, {k >= 12, k == 12, k == 12});
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] e;
        logic [7:0] d, p, prev_p;
        int hold[8];
        int last[8];
        d = din;
        prev_p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            hold[i] = 0;
            last[i] = -100;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (hold[i] == 0) begin
                    d[i] = ~d[i];
                    hold[i] = $urandom_range(1, 9);
                end else hold[i]--;
            end
            tick(d, 1'b0);
            e = q_exp.pop_front();
            n_checks++;
            if ({dout, rise, fall, change} !== e) begin
                n_err++;
                $display("FAIL random_sb cyc=%0d got=%h exp=%h", c, {dout, rise, fall, change}, e);
            end
            p = rise | fall;
            n_checks++;
            if ((p & prev_p) !== 8'h00) begin
                n_err++;
                $display("FAIL random_width cyc=%0d got=%h exp=00", c, p & prev_p);
            end
            for (int i = 0; i < 8; i++) begin
                if (p[i]) begin
                    n_checks++;
                    if (c - last[i] < 4) begin
                        n_err++;
                        $display("FAIL random_spacing ch=%0d got=%0d exp>=4", i, c - last[i]);
                    end
                    last[i] = c;
                end
            end
            prev_p = p;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
